mux4_arbiter: RTL and testbench

Round-robin arbiter that shares one `mux4` sample path between four audio sources. It drives the 2-bit mux control and grants the path to one requester at a time for a bounded burst of samples. It presents the selected sample to a downstream consumer through a valid/ready handshake and returns per-source acknowledges. It sits between the source blocks (ADC capture, tone generators, playback buffers) and the shared processing chain.

---
 rtl/mux4_arbiter.sv | 100 ++++++++++
 tb/tb_mux4_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter sharing one mux4 sample path between four sources.
// Grants one source per burst of up to BURST samples and presents data via valid/ready.
module mux4_arbiter #(
  parameter int REGBITS = 16,
  parameter int BURST   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         req,
  input  logic [REGBITS-1:0] a,
  input  logic [REGBITS-1:0] b,
  input  logic [REGBITS-1:0] c,
  input  logic [REGBITS-1:0] d,
  input  logic               data_ready,
  output logic [1:0]         control,
  output logic [3:0]         grant,
  output logic [REGBITS-1:0] data_out,
  output logic               data_valid,
  output logic [3:0]         ack
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t        state;
  logic [1:0]    last;
  logic [CW-1:0] count;
  logic [1:0]    pick;
  logic [1:0]    cand;
  logic          found;
  logic          xfer;
  logic          burst_done;

  // Scan last+1 .. last+4 (mod 4); the final candidate is last itself.
  always_comb begin
    pick  = last;
    cand  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    case (control)
      2'b00:   data_out = a;
      2'b01:   data_out = b;
      2'b10:   data_out = c;
      default: data_out = d;
    endcase
  end

  assign data_valid = (state == SERVE) && req[control];
  assign xfer       = data_valid && data_ready;
  assign burst_done = (count == CW'(BURST - 1));

  always_comb begin
    ack = '0;
    if (xfer) ack[control] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      control <= '0;
      grant   <= '0;
      count   <= '0;
      last    <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            control <= pick;
            grant   <= 4'b0001 << pick;
            count   <= '0;
            state   <= SERVE;
          end else begin
            grant <= '0;
          end
        end
        SERVE: begin
          if (!req[control] || (xfer && burst_done)) begin
            last  <= control;
            grant <= '0;
            state <= IDLE;
          end else if (xfer) begin
            count <= count + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Scoreboard bench for mux4_arbiter: a transaction-level owner/burst model predicts
// per-cycle grant/valid and each consumed sample; a monitor compares against the DUT.
module tb_mux4_arbiter;
  localparam int REGBITS = 16;
  localparam int BURST   = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [3:0]         req = '0;
  logic [REGBITS-1:0] a = '0, b = '0, c = '0, d = '0;
  logic               data_ready = 1'b0;
  logic [1:0]         control;
  logic [3:0]         grant;
  logic [REGBITS-1:0] data_out;
  logic               data_valid;
  logic [3:0]         ack;

  mux4_arbiter #(.REGBITS(REGBITS), .BURST(BURST)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .a(a), .b(b), .c(c), .d(d),
    .data_ready(data_ready), .control(control), .grant(grant),
    .data_out(data_out), .data_valid(data_valid), .ack(ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]         grant;
    logic               valid;
    logic [REGBITS-1:0] data;
  } cyc_t;

  typedef struct {
    int                 src;
    logic [REGBITS-1:0] data;
  } xfer_t;

  cyc_t  cyc_q[$];
  xfer_t xfer_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;

  // Reference model: who owns the path, how many samples it has sent, who was served last.
  int owner = -1;
  int sent  = 0;
  int last  = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rd);
    logic [REGBITS-1:0] s[4];
    cyc_t               e;
    xfer_t              x;
    @(negedge clk);
    req = r;
    data_ready = rd;
    a = REGBITS'($urandom);
    b = REGBITS'($urandom);
    c = REGBITS'($urandom);
    d = REGBITS'($urandom);
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    e.grant = '0;
    e.valid = 1'b0;
    e.data  = '0;
    if (owner >= 0) begin
      e.grant = 4'(1 << owner);
      e.valid = r[owner];
      e.data  = s[owner];
    end
    cyc_q.push_back(e);
    if (owner >= 0) begin
      if (!r[owner]) begin
        last  = owner;
        owner = -1;
      end else if (rd) begin
        x.src  = owner;
        x.data = s[owner];
        xfer_q.push_back(x);
        sent++;
        if (sent == BURST) begin
          last  = owner;
          owner = -1;
        end
      end
    end else if (r != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        if (r[(last + k) % 4]) begin
          owner = (last + k) % 4;
          break;
        end
      end
      sent = 0;
    end
  endtask

  // Monitor: samples 2 time units after each falling edge, after the driver has settled inputs.
  initial begin
    cyc_t  e;
    xfer_t x;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        check("grant", 32'(grant), 32'(e.grant));
        check("data_valid", 32'(data_valid), 32'(e.valid));
        if (e.valid) check("data_out", 32'(data_out), 32'(e.data));
        if (ack != 4'b0000) begin
          if (xfer_q.size() == 0) begin
            check("unexpected_ack", 32'(ack), 32'h0);
          end else begin
            x = xfer_q.pop_front();
            check("ack", 32'(ack), 32'(1 << x.src));
            check("ack_control", 32'(control), 32'(x.src));
            check("ack_data", 32'(data_out), 32'(x.data));
          end
        end
        check("missing_ack", 32'(xfer_q.size()), 32'h0);
      end
    end
  end

  initial begin
    logic [3:0] r;
    #1;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_control", 32'(control), 32'h0);
    check("reset_valid", 32'(data_valid), 32'h0);
    check("reset_ack", 32'(ack), 32'h0);
    #11;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Single source streaming, then all four competing.
    for (int i = 0; i < 20; i++) step(4'b0001, 1'b1);
    for (int i = 0; i < 45; i++) step(4'b1111, 1'b1);
    // Backpressure on source 1 after two transfers.
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b0);
    for (int i = 0; i < 2; i++) step(4'b0010, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0010, 1'b1);
    // Source 2 drops after two acks with source 3 waiting.
    step(4'b0000, 1'b0);
    step(4'b1100, 1'b1);
    step(4'b1100, 1'b1);
    step(4'b1100, 1'b1);
    for (int i = 0; i < 6; i++) step(4'b1000, 1'b1);

    // Asynchronous reset in the middle of a held burst.
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0);
    #5;
    check("pre_reset_valid", 32'(data_valid), 32'h1);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_reset_grant", 32'(grant), 32'h0);
    check("async_reset_control", 32'(control), 32'h0);
    check("async_reset_valid", 32'(data_valid), 32'h0);
    check("async_reset_ack", 32'(ack), 32'h0);
    #20;
    reset_n = 1'b1;
    owner = -1;
    sent  = 0;
    last  = 3;
    cyc_q.delete();
    xfer_q.delete();
    mon_en = 1'b1;

    // Wrap: source 2 served first, then source 0 wins over a re-requesting source 2.
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    step(4'b0101, 1'b0);
    step(4'b0001, 1'b0);
    for (int i = 0; i < 6; i++) step(4'b0101, 1'b1);

    // Random sticky requests with random backpressure.
    r = 4'($urandom);
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 3) == 0) r[k] = ~r[k];
      step(r, $urandom_range(0, 3) != 0);
    end
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    @(negedge clk);
    #4;
    check("final_cyc_queue", 32'(cyc_q.size()), 32'h0);
    check("final_xfer_queue", 32'(xfer_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
